// File: rtl/lift_pkg.sv
// lift_pkg: shared types, constants and floor-mask helpers for the lift scheduler.
// S_ESTOP exists only when LIFT_ESTOP_EN is defined.
package lift_pkg;
  localparam int N_FLOORS = 4;
  localparam int ANDAR_W = 2;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP    = 3'd1,
    S_DOWN  = 3'd2,
    S_STOP  = 3'd3,
    S_OPEN  = 3'd4,
`ifdef LIFT_ESTOP_EN
    S_CLOSE = 3'd5,
    S_ESTOP = 3'd6
`else
    S_CLOSE = 3'd5
`endif
  } state_t;
  function automatic logic [N_FLOORS-1:0] mask_above(input logic [ANDAR_W-1:0] f);
    logic [N_FLOORS-1:0] one;
    one = N_FLOORS'(1);
    return ~(((one << f) << 1) - one);
  endfunction
  function automatic logic [N_FLOORS-1:0] mask_below(input logic [ANDAR_W-1:0] f);
    logic [N_FLOORS-1:0] one;
    one = N_FLOORS'(1);
    return (one << f) - one;
  endfunction
endpackage

// File: rtl/andar_filtro.sv
// andar_filtro: confirms a floor only after STABLE_CYCLES consecutive identical valid samples.
module andar_filtro
  import lift_pkg::*;
#(
  parameter int STABLE_CYCLES = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ANDAR_W-1:0] andar,
  input  logic               andar_valido,
  output logic [ANDAR_W-1:0] andar_atual
);
  logic [ANDAR_W-1:0] r_cand, w_cand;
  logic [3:0] r_cnt, w_cnt;
  always_comb begin
    w_cand = andar_valido ? andar : r_cand;
    w_cnt = !andar_valido ? r_cnt : (andar != r_cand) ? 4'd1 :
            (r_cnt < 4'(STABLE_CYCLES)) ? r_cnt + 4'd1 : r_cnt;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cand <= '0;
      r_cnt <= '0;
      andar_atual <= '0;
    end else begin
      r_cand <= w_cand;
      r_cnt <= w_cnt;
      if (andar_valido && w_cnt == 4'(STABLE_CYCLES)) andar_atual <= w_cand;
    end
  end
endmodule

// File: rtl/lift_scheduler.sv
// lift_scheduler: SCAN call scheduler driving motor and door with filtered floor input.
// Defining LIFT_ESTOP_EN adds the emergencia input and the ESTOP state.
module lift_scheduler
  import lift_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int DOOR_CYCLES = 50,
  parameter int CLOSE_CYCLES = 10
) (
  input  logic                clock,
  input  logic                reset,
`ifdef LIFT_ESTOP_EN
  input  logic                emergencia,
`endif
  input  logic [N_FLOORS-1:0] chamada,
  input  logic [ANDAR_W-1:0]  andar,
  input  logic                andar_valido,
  output logic                sobe,
  output logic                desce,
  output logic                porta_aberta,
  output logic [ANDAR_W-1:0]  andar_atual,
  output logic [N_FLOORS-1:0] pendentes,
  output logic [2:0]          estado_db
);
  localparam logic [ANDAR_W-1:0] TOP_FLOOR = ANDAR_W'(N_FLOORS - 1);
  state_t r_state, w_next;
  logic [7:0] r_tmr;
  logic r_dir;
  logic [ANDAR_W-1:0] r_prev;
  logic w_here, w_above, w_below, w_chg, w_tmr_one, w_clr;
  logic [N_FLOORS-1:0] w_open_clr;
  andar_filtro #(.STABLE_CYCLES(STABLE_CYCLES)) u_filtro (
    .clock(clock),
    .reset(reset),
    .andar(andar),
    .andar_valido(andar_valido),
    .andar_atual(andar_atual)
  );
  assign w_here = pendentes[andar_atual];
  assign w_above = |(pendentes & mask_above(andar_atual));
  assign w_below = |(pendentes & mask_below(andar_atual));
  assign w_chg = andar_atual != r_prev;
  assign w_tmr_one = r_tmr == 8'd1;
  assign w_open_clr = (r_state == S_OPEN) ? (N_FLOORS'(1) << andar_atual) : '0;
  assign estado_db = r_state;
`ifdef LIFT_ESTOP_EN
  assign w_clr = emergencia || r_state == S_ESTOP;
`else
  assign w_clr = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_here ? S_OPEN : (w_above && w_below) ? (r_dir == DIR_UP ? S_UP : S_DOWN) :
                        w_above ? S_UP : w_below ? S_DOWN : S_IDLE;
      S_UP:    w_next = (andar_atual == TOP_FLOOR || (w_chg && (w_here || !w_above))) ? S_STOP : S_UP;
      S_DOWN:  w_next = (andar_atual == '0 || (w_chg && (w_here || !w_below))) ? S_STOP : S_DOWN;
      S_STOP:  w_next = S_OPEN;
      // A call for the current floor holds the door even on its last cycle
      S_OPEN:  w_next = (w_tmr_one && !chamada[andar_atual]) ? S_CLOSE : S_OPEN;
      S_CLOSE: w_next = w_tmr_one ? S_IDLE : S_CLOSE;
`ifdef LIFT_ESTOP_EN
      S_ESTOP: w_next = emergencia ? S_ESTOP : S_CLOSE;
`endif
      default: w_next = S_IDLE;
    endcase
`ifdef LIFT_ESTOP_EN
    if (emergencia) w_next = S_ESTOP;
`endif
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tmr <= '0;
      r_dir <= DIR_UP;
      r_prev <= '0;
      pendentes <= '0;
      sobe <= 1'b0;
      desce <= 1'b0;
      porta_aberta <= 1'b0;
    end else begin
      r_state <= w_next;
      r_prev <= andar_atual;
      sobe <= w_next == S_UP;
      desce <= w_next == S_DOWN;
      porta_aberta <= w_next == S_OPEN;
      r_dir <= (w_next == S_UP) ? DIR_UP : (w_next == S_DOWN) ? DIR_DOWN : r_dir;
      r_tmr <= (w_next == S_OPEN && (r_state != S_OPEN || chamada[andar_atual])) ? 8'(DOOR_CYCLES) :
               (w_next == S_CLOSE && r_state != S_CLOSE) ? 8'(CLOSE_CYCLES) :
               (r_tmr != 8'd0) ? r_tmr - 8'd1 : 8'd0;
      pendentes <= w_clr ? '0 : (pendentes | chamada) & ~w_open_clr;
    end
  end
endmodule

// File: doc/lift_scheduler.md
Name: lift_scheduler

Overview:
- Sequences the PoLift cargo elevator: latches floor calls, drives motor up/down, runs door timing.
- Floor position comes from the height-to-floor conversion path (2-bit floor from BCD cm height), stability-filtered inside this block.
- Services calls with a SCAN policy: keep the current direction while calls remain ahead, otherwise reverse.

Parameters:
- N_FLOORS, 4, number of floors; floor index width is 2 bits.
- STABLE_CYCLES, 3, consecutive identical valid floor samples required to confirm a floor change (range 1..15).
- DOOR_CYCLES, 50, clock cycles the door stays open (range 1..255).
- CLOSE_CYCLES, 10, clock cycles in the door-closing phase before motion is allowed (range 1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- chamada  in  4  floor call pulses, bit i = floor i; several bits may be high in the same cycle.
- andar  in  2  floor reported by the height conversion path.
- andar_valido  in  1  andar sample valid this cycle.
- sobe  out  1  motor up command.
- desce  out  1  motor down command.
- porta_aberta  out  1  door open command.
- andar_atual  out  2  confirmed (filtered) floor.
- pendentes  out  4  pending call register.
- estado_db  out  3  FSM state code, for debug.

Behaviour:
- Reset is sampled on the rising clock edge while reset=0. Reset values:
  - all outputs 0; pendentes=0; andar_atual=0; state IDLE.
  - direction register = UP; all counters 0.
- Reset applied mid-motion takes effect at the next edge: motor off, calls lost.
- Floor filter:
  - candidate/count register; counts only cycles with andar_valido=1.
  - andar different from candidate → candidate=andar, count=1.
  - count reaching STABLE_CYCLES → andar_atual=candidate.
  - invalid cycles hold the count.
  - andar_atual updates one cycle after the confirming sample.
- Calls:
  - pendentes |= chamada every cycle.
  - In OPEN, bit andar_atual is cleared every cycle. Clear wins over a simultaneous set for that floor; the door timer also restarts to DOOR_CYCLES.
- State codes: IDLE=0, UP=1, DOWN=2, STOP=3, OPEN=4, CLOSE=5.
- IDLE transitions, in priority order:
  - pendentes[andar_atual] → OPEN.
  - Calls above and below both pending → follow the direction register.
  - Calls only above → UP.
  - Calls only below → DOWN.
  - No calls → stay in IDLE.
  - Direction register is updated on entering UP or DOWN.
- UP:
  - sobe=1.
  - On a confirmed andar_atual change, if pendentes[andar_atual] or no calls above → STOP.
  - andar_atual=3 → STOP unconditionally.
- DOWN: mirror of UP; forced STOP at floor 0.
- STOP: motor off for exactly 1 cycle → OPEN.
- OPEN:
  - porta_aberta=1.
  - Timer loads DOOR_CYCLES on entry, decrements each cycle; at 1 → CLOSE.
  - Open time is DOOR_CYCLES cycles, longer if restarted by a call.
- CLOSE: porta_aberta=0; CLOSE_CYCLES cycles → IDLE.
- Invariants:
  - sobe and desce are never both 1.
  - Motor is never on while porta_aberta=1, or in STOP or CLOSE.
  - Outputs are registered (Moore).
- A confirmed floor jump greater than 1 is accepted as-is; the stop decision uses the new floor.
- Heights ≥120 cm decode to floor 0 upstream; the filter treats this as a normal sample.

Optional Feature:
- Macro: LIFT_ESTOP_EN.
- When defined:
  - Adds input emergencia (1 bit) and state ESTOP=6.
  - emergencia=1 from any state → next cycle ESTOP: sobe=desce=porta_aberta=0; pendentes cleared and held at 0.
  - emergencia=0 → CLOSE (full CLOSE_CYCLES) → IDLE.
  - Emergency has priority over all transitions except reset.
- When undefined: no port, no state; code 6 unreachable.

Decomposition:
- Package lift_pkg:
  - state enum with the codes above;
  - N_FLOORS and ANDAR_W=2;
  - DIR_UP/DIR_DOWN constants.
- One sub-module, andar_filtro: the floor stability filter (andar, andar_valido → andar_atual), parameterised by STABLE_CYCLES.
- FSM, call register and timers stay in lift_scheduler.

Test Plan:
(bench parameters STABLE_CYCLES=2, DOOR_CYCLES=4, CLOSE_CYCLES=2)
- Reset: hold reset=0 for 2 edges with motor running → all outputs 0, estado_db=0, pendentes=0.
- Same-floor call: at floor 0, pulse chamada=0001 → OPEN next cycle; porta_aberta high 4 cycles; then 2 CLOSE cycles; IDLE; pendentes=0.
- Up trip with intermediate stop:
  - Start at floor 0, pulse chamada=1010 → UP.
  - Feed andar=1 for 2 valid cycles → STOP, OPEN at floor 1, bit 1 cleared.
  - Then UP to floor 3 → stop, pendentes=0.
- SCAN tie-break: at floor 1 with direction UP, pendentes=1001 → UP first; after servicing floor 3 → DOWN to floor 0.
- Filter glitch: during UP, andar toggles 1,0,1 with valid=1 → andar_atual holds until 2 consecutive equal samples; andar_valido=0 cycles do not advance the count.
- Door restart: in OPEN at floor 2 with 1 cycle left, pulse chamada=0100 → timer reloads to 4, bit 2 stays 0.
- With LIFT_ESTOP_EN: emergencia=1 while UP → next cycle sobe=0, estado_db=6, pendentes=0; release → CLOSE 2 cycles → IDLE.
